// File: rtl/blit_mem_arb.sv
// blit_mem_arb: arbitrates the blitter-internal memory requesters (source read, dest read,
// Z read, dest/Z write) onto the single request port of the blitter memory controller.
//
// Ports
//   clk, reset_n        blitter clock, asynchronous active-low reset
//   req                 per-requester request level, held until its done pulse
//   req_write           per-requester cycle type (1 = write), sampled at grant
//   req_addr            packed addresses, requester i at [i*AW +: AW]
//   req_width           packed phrase widths, requester i at [i*4 +: 4]
//   prio_fixed          1 = fixed priority (index 0 highest), 0 = round robin
//   blitack, read_ack   controller accept / read-data-returned handshakes
//   grant               one-hot current owner
//   done                one-cycle completion pulse to the owner
//   readreq, writereq   request strobes to the controller
//   address, pwidth     registered address / phrase width of the owner
//   busy                arbiter not idle
//   timeout_err         sticky watchdog flag, cleared only by reset
module blit_mem_arb #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned AW       = 24,
   parameter int unsigned WAIT_MAX = 255
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ-1:0]      req_write,
   input  logic [NREQ*AW-1:0]   req_addr,
   input  logic [NREQ*4-1:0]    req_width,
   input  logic                 prio_fixed,
   input  logic                 blitack,
   input  logic                 read_ack,
   output logic [NREQ-1:0]      grant,
   output logic [NREQ-1:0]      done,
   output logic                 readreq,
   output logic                 writereq,
   output logic [AW-1:0]        address,
   output logic [3:0]           pwidth,
   output logic                 busy,
   output logic                 timeout_err
);

   localparam int unsigned PW      = $clog2(NREQ);
   // Counter value seen in the WAIT_MAX-th cycle spent in REQ/WAIT.
   localparam logic [7:0]  CntLast = 8'(WAIT_MAX - 1);

   typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] grant_q, grant_d;
   logic            write_q, write_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [3:0]      pw_q, pw_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [7:0]      cnt_q, cnt_d;
   logic            tmo_q, tmo_d;

   logic            win_found;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   cand;
   logic            limit;

   assign limit = (cnt_q == CntLast);

   // Winner search: fixed mode scans 0 upwards, round robin scans from the slot after the
   // pointer and wraps, so the previous owner is considered last.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         if (prio_fixed) begin
            cand = PW'(k - 1);
         end else begin
            cand = PW'((int'(ptr_q) + k) % int'(NREQ));
         end
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      write_d = write_q;
      addr_d  = addr_q;
      pw_d    = pw_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      tmo_d   = tmo_q;
      unique case (state_q)
         StIdle: begin
            if (win_found) begin
               state_d          = StReq;
               grant_d          = '0;
               grant_d[win_idx] = 1'b1;
               write_d          = req_write[win_idx];
               addr_d           = req_addr[int'(win_idx)*AW +: AW];
               pw_d             = req_width[int'(win_idx)*4 +: 4];
               ptr_d            = win_idx;
               cnt_d            = '0;
            end
         end
         StReq: begin
            cnt_d = cnt_q + 8'd1;
            // A normal completion in the last watchdog cycle wins over the timeout.
            if (blitack && (write_q || read_ack)) begin
               state_d = StDone;
            end else if (limit) begin
               state_d = StDone;
               tmo_d   = 1'b1;
            end else if (blitack) begin
               state_d = StWait;
            end
         end
         StWait: begin
            cnt_d = cnt_q + 8'd1;
            if (read_ack) begin
               state_d = StDone;
            end else if (limit) begin
               state_d = StDone;
               tmo_d   = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            grant_d = '0;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         grant_q <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         pw_q    <= '0;
         ptr_q   <= PW'(NREQ - 1);
         cnt_q   <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         write_q <= write_d;
         addr_q  <= addr_d;
         pw_q    <= pw_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         tmo_q   <= tmo_d;
      end
   end

   assign grant       = grant_q;
   assign done        = (state_q == StDone) ? grant_q : '0;
   assign readreq     = (state_q == StReq) && !write_q;
   assign writereq    = (state_q == StReq) && write_q;
   assign address     = addr_q;
   assign pwidth      = pw_q;
   assign busy        = (state_q != StIdle);
   assign timeout_err = tmo_q;

endmodule
